// File: rtl/systolic_row_feeder.sv
// Captures a DIM x DIM tile row by row, replays it onto a DIM-lane bus, then
// emits DIM-1 zero beats so every lane's downstream delay line flushes.
module systolic_row_feeder #(
    parameter int DIM  = 8,
    parameter int BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIM*BITS-1:0] in_data,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DIM*BITS-1:0] out_data,
    output logic                fifo_en,
    output logic                busy,
    output logic                done
);

    // Handshake: a beat moves on a rising edge where valid && ready are both
    // high. valid never depends on ready, and while valid is high without
    // ready the data is held unchanged.

    localparam int AW = $clog2(DIM);
    localparam int CW = $clog2(DIM) + 1;
    localparam logic [CW-1:0] LAST_ROW   = CW'(DIM - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(DIM - 2);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [DIM*BITS-1:0] mem_q [DIM];
    logic [DIM*BITS-1:0] mem_d [DIM];
    logic [AW-1:0]      idx;

    // cnt never exceeds DIM-1, so the low bits address the row directly
    assign idx = cnt_q[AW-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        for (int r = 0; r < DIM; r++) begin
            mem_d[r] = mem_q[r];
        end

        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_d[idx] = in_data;
                    if (cnt_q == LAST_ROW) begin
                        cnt_d   = '0;
                        state_d = ST_STREAM;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                out_data  = mem_q[idx];
                if (out_ready) begin
                    if (cnt_q == LAST_ROW) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt_q == LAST_DRAIN) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    assign fifo_en = out_valid & out_ready;
    assign busy    = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    assign done    = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int r = 0; r < DIM; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            for (int r = 0; r < DIM; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Directed bench for systolic_row_feeder (DIM=8, BITS=8): a vector table for the
// basic tile plus hand-written sequences for gaps, stalls, resets and reuse.
module tb_systolic_row_feeder;

    localparam int DIM  = 8;
    localparam int BITS = 8;
    localparam int W    = DIM * BITS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         fifo_en;
    logic         busy;
    logic         done;
    logic [4:0]   ctl;

    int tests = 0;
    int fails = 0;
    int beats = 0;
    logic [W-1:0] exp_q[$];

    systolic_row_feeder #(.DIM(DIM), .BITS(BITS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .fifo_en(fifo_en), .busy(busy), .done(done)
    );

    assign ctl = {in_ready, out_valid, fifo_en, busy, done};

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic         iv;
        logic [W-1:0] data;
        logic         ordy;
        logic [4:0]   exp_ctl;
    } vec_t;

    vec_t vecs[25];

    function automatic logic [W-1:0] tile_row(input int t, input int r);
        logic [W-1:0] v;
        for (int i = 0; i < DIM; i++) begin
            case (t)
                0:       v[i*BITS +: BITS] = 8'(r * 16 + i);
                1:       v[i*BITS +: BITS] = 8'((r * 16 + i) ^ 8'h55);
                default: v[i*BITS +: BITS] = 8'hFF;
            endcase
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard: every accepted output beat must match the head of exp_q
    task automatic monitor();
        if (fifo_en === 1'b1) begin
            beats++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_beat", out_data, '1);
            end else begin
                check("sb_beat", out_data, exp_q.pop_front());
            end
        end
    endtask

    // driver: apply inputs on the falling edge, observe 1ns later
    task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic r);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        monitor();
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("reset_ctl", 64'(ctl), 64'(5'b10000));
        exp_q.delete();
        beats = 0;
    endtask

    task automatic push_tile(input int t);
        for (int r = 0; r < DIM; r++) exp_q.push_back(tile_row(t, r));
        for (int r = 0; r < DIM - 1; r++) exp_q.push_back('0);
    endtask

    task automatic load_tile(input int t);
        push_tile(t);
        for (int r = 0; r < DIM; r++) begin
            drive(1'b1, tile_row(t, r), 1'b0, 1'b0);
            check("load_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    task automatic stream_out(input logic iv, input logic [W-1:0] id, output int done_cyc);
        done_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            drive(iv, id, 1'b1, 1'b0);
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic tile_end(input string name, input int done_cyc, input int exp_cyc);
        check({name, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
        check({name, "_beats"}, 64'(beats), 64'd15);
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_idle_ctl"}, 64'(ctl), 64'(5'b10001));
    endtask

    initial begin
        int dc;

        for (int k = 0; k < 25; k++) begin
            if (k < 8) vecs[k] = '{1'b1, tile_row(0, k), 1'b1, 5'b10000};
            else if (k < 23) vecs[k] = '{1'b1, tile_row(0, 7), 1'b1, 5'b01110};
            else if (k == 23) vecs[k] = '{1'b0, '0, 1'b1, 5'b10001};
            else vecs[k] = '{1'b0, '0, 1'b1, 5'b10000};
        end

        // 1: back-to-back rows, no stalls
        do_reset();
        push_tile(0);
        for (int k = 0; k < 25; k++) begin
            drive(vecs[k].iv, vecs[k].data, vecs[k].ordy, 1'b0);
            check($sformatf("t1_ctl[%0d]", k), 64'(ctl), 64'(vecs[k].exp_ctl));
        end
        check("t1_beats", 64'(beats), 64'd15);
        check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // 2: gapped input, accepts on even cycles only
        do_reset();
        push_tile(0);
        for (int k = 0; k < 15; k++) begin
            if (k % 2 == 0) drive(1'b1, tile_row(0, k / 2), 1'b1, 1'b0);
            else drive(1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0);
            check($sformatf("t2_load_ctl[%0d]", k), 64'({in_ready, out_valid}), 64'(2'b10));
        end
        stream_out(1'b0, '0, dc);
        tile_end("t2", dc, 15);

        // 3: output stalls on row 2 (3 cycles) and drain beat 4 (2 cycles)
        do_reset();
        load_tile(0);
        dc = -1;
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, '0, !(c inside {2, 3, 4, 15, 16}), 1'b0);
            if (c >= 2 && c <= 4) begin
                check("t3_hold_row2", 64'(out_data[7:0]), 64'h20);
                check("t3_stall_fifo_en", 64'(fifo_en), 64'd0);
            end
            if (c == 15 || c == 16) begin
                check("t3_drain_stall", {63'd0, fifo_en}, 64'd0);
            end
            if (done === 1'b1) begin
                dc = c;
                break;
            end
        end
        tile_end("t3", dc, 20);

        // 4: reset while row 4 is presented, then a fresh tile
        do_reset();
        load_tile(0);
        for (int c = 0; c < 4; c++) drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("t4_row4_shown", 64'(out_data[7:0]), 64'h40);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("t4_after_rst_ctl", 64'(ctl), 64'(5'b10000));
        exp_q.delete();
        beats = 0;
        load_tile(1);
        stream_out(1'b0, '0, dc);
        tile_end("t4", dc, 15);

        // 5: second tile offered on the done cycle
        do_reset();
        load_tile(0);
        for (int c = 0; c < 15; c++) drive(1'b0, '0, 1'b1, 1'b0);
        check("t5_first_beats", 64'(beats), 64'd15);
        beats = 0;
        push_tile(2);
        drive(1'b1, tile_row(2, 0), 1'b1, 1'b0);
        check("t5_done_accept", 64'({in_ready, done, busy}), 64'(3'b110));
        for (int r = 1; r < DIM; r++) begin
            drive(1'b1, tile_row(2, r), 1'b0, 1'b0);
            check("t5_load_in_ready", 64'(in_ready), 64'd1);
        end
        stream_out(1'b0, '0, dc);
        tile_end("t5", dc, 15);

        // 6: ignored traffic in both directions
        do_reset();
        push_tile(1);
        for (int r = 0; r < DIM; r++) begin
            drive(1'b1, tile_row(1, r), 1'(r % 2), 1'b0);
            check("t6_load_fifo_en", 64'(fifo_en), 64'd0);
        end
        stream_out(1'b1, {8{8'hAA}}, dc);
        tile_end("t6", dc, 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_row_feeder.md
Name: systolic_row_feeder

Overview:
- Upstream stage of the per-lane delay FIFOs that feed the systolic MAC array.
- Captures a DIM x DIM tile, one row per valid/ready transfer, from the host/MMIO side. Then replays the tile row by row onto a DIM-lane bus with a shift enable for the delay FIFOs.
- After the last row it emits DIM-1 zero "drain" beats so every lane's delay line flushes the real data into the array.
- Pulses done once the tile has been fully pushed.

Parameters:
- DIM, 8, rows/columns of the tile and number of output lanes; legal range 2..64.
- BITS, 8, width of one matrix element.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_data holds a valid row.
- in_ready  output  1  block accepts a row this cycle.
- in_data  input  DIM*BITS  row; lane i = in_data[i*BITS +: BITS].
- out_ready  input  1  downstream may advance this cycle.
- out_valid  output  1  out_data holds a beat (row or drain zero).
- out_data  output  DIM*BITS  beat; lane i = out_data[i*BITS +: BITS].
- fifo_en  output  1  shift enable for the delay FIFOs; equals out_valid & out_ready.
- busy  output  1  high in STREAM or DRAIN.
- done  output  1  one-cycle pulse after the final drain beat is accepted.

Behaviour:
- Storage: DIM x DIM x BITS register array mem[row][lane]. Counter cnt is $clog2(DIM)+1 bits wide.
- Reset (rst=1 at clk edge):
  - state=LOAD, cnt=0, all mem entries 0.
  - Registered outputs: out_valid=0, done=0, busy=0. in_ready=1 once in LOAD.
  - Reset wins over every other event, including mid-STREAM or mid-DRAIN. The partial tile is discarded and done is not pulsed.
- LOAD state:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: mem[cnt] <= in_data, cnt++.
  - When the transfer with cnt==DIM-1 is accepted: cnt<=0, state<=STREAM. in_ready is 0 from the next cycle.
- STREAM state:
  - out_valid=1, out_data=mem[cnt] (combinational read of the registered array), in_ready=0.
  - On out_ready: cnt++. When cnt==DIM-1 is accepted: cnt<=0, state<=DRAIN.
  - out_ready=0 holds out_data stable, with fifo_en=0.
- DRAIN state:
  - out_valid=1, out_data=0, in_ready=0.
  - On out_ready: cnt++. When cnt==DIM-2 is accepted: cnt<=0, state<=LOAD, done<=1 for exactly one cycle.
- done is registered: it is high in the first LOAD cycle after drain, the same cycle in_ready returns to 1. A new tile may be accepted in that cycle.
- busy=1 exactly when state is STREAM or DRAIN.
- No transfer is ever lost or duplicated. Each row is emitted exactly once, in arrival order.
- A new tile load overwrites mem rows in order; there is no clear between tiles.
- in_valid during STREAM/DRAIN is ignored; the row must be held by the upstream until in_ready.
- out_ready during LOAD has no effect, and fifo_en stays 0.
- Total accepted output beats per tile = 2*DIM-1. Minimum tile turnaround with no stalls = DIM load cycles + 2*DIM-1 output cycles.

Test Plan:
- Reset then back-to-back rows: row r lane i = r*16+i, with in_valid=1 and out_ready=1 throughout.
  - Required: in_ready drops after 8 accepts.
  - out_data lane i = r*16+i on beats 0..7, then 7 beats of 0.
  - fifo_en high for 15 consecutive cycles, then done=1 for one cycle, busy=0.
- Gapped input: in_valid toggled 1,0,1,0 per cycle.
  - Required: only accepted rows are stored, and stream starts only after the 8th accept.
  - Output sequence is identical to the first test.
- Output backpressure: out_ready=0 for 3 cycles during row 2 and for 2 cycles during drain beat 4.
  - Required: out_data holds row 2 (lane0=0x20) stable, with fifo_en=0 during stalls.
  - Still exactly 15 fifo_en pulses, and done is delayed by 5 cycles.
- Reset mid-stream: rst=1 while row 4 is presented.
  - Required next cycle: out_valid=0, busy=0, done=0, in_ready=1, cnt=0.
  - A fresh tile then streams correctly.
- Back-to-back tiles: second tile (all lanes 0xFF) offered on the done cycle.
  - Required: it is accepted that same cycle.
  - Second stream emits 0xFF on all lanes for 8 beats with no stale data from tile 1.
- Ignored traffic: in_valid=1 with in_data=0xAA.. during STREAM, and out_ready pulsed during LOAD.
  - Required: mem unchanged, the stream emits the original tile, and fifo_en=0 during LOAD.
